key_expansion_controller: RTL and testbench

Sequencing and storage stage wrapped around the N-word sequential key scheduler. It accepts a full AES-256 cipher key and drives the scheduler's word inputs, index and valid once per cycle. It closes the feedback loop on the scheduler's output bus and stores the 15 resulting 128-bit round keys in a register file. The round datapath reads those keys through a registered read port once `o_done` is high.

---
 rtl/key_expansion_controller.sv | 201 ++++++++++++++++++++
 tb/tb_key_expansion_controller.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_controller.sv
// ---------------------------------------------------------------------------
// key_expansion_controller
//
// Sequencing and storage stage around the N-word sequential AES-256 key
// scheduler. A cipher key strobed in on i_key_valid seeds round keys 0 and 1.
// The controller then issues scheduler steps 2..N_ROUNDS back to back, one
// per cycle, and captures each 128-bit result as the next round key. The
// round keys sit in a register file with a registered read port for the
// round datapath.
//
// Ports:
//   i_clock, i_reset              clock, asynchronous active-high reset
//   i_key, i_key_valid            cipher key (word 0 in MSBs) and start strobe
//   o_sched_key_word_n_m_1        word n-1 to the scheduler
//   o_sched_key_word_n_m_nk_bus   words n-8..n-5 to the scheduler (first in MSBs)
//   o_sched_index, o_sched_valid  step number and enable for the scheduler
//   i_sched_key_word_n_bus        scheduler result, one cycle after o_sched_valid
//   i_rd_round, o_round_key       round-key read address / registered read data
//   o_busy, o_done                expansion running / all round keys valid
// ---------------------------------------------------------------------------
module key_expansion_controller #(
  parameter int NB_BYTE       = 8,
  parameter int N_BYTES_STATE = 16,
  parameter int N_BYTES_KEY   = 32,
  parameter int N_ROUNDS      = 14,
  parameter int N_WORDS       = 4,
  parameter int N_BYTES_WORD  = 4,
  parameter int NB_WORD       = N_BYTES_WORD * NB_BYTE,
  parameter int NB_INDEX      = 4,
  parameter int NB_STATE      = N_BYTES_STATE * NB_BYTE,
  parameter int NB_KEY        = N_BYTES_KEY * NB_BYTE
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [NB_KEY-1:0]          i_key,
  input  logic                       i_key_valid,
  output logic [NB_WORD-1:0]         o_sched_key_word_n_m_1,
  output logic [N_WORDS*NB_WORD-1:0] o_sched_key_word_n_m_nk_bus,
  output logic [NB_INDEX-1:0]        o_sched_index,
  output logic                       o_sched_valid,
  input  logic [N_WORDS*NB_WORD-1:0] i_sched_key_word_n_bus,
  input  logic [NB_INDEX-1:0]        i_rd_round,
  output logic [NB_STATE-1:0]        o_round_key,
  output logic                       o_busy,
  output logic                       o_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Round keys 0 and 1 come straight from the cipher key, so scheduling
  // starts at step 2 and ends at step N_ROUNDS.
  localparam logic [NB_INDEX-1:0] FIRST_STEP = NB_INDEX'(2);
  localparam logic [NB_INDEX-1:0] LAST_STEP  = NB_INDEX'(N_ROUNDS);

  state_t                state_reg;
  state_t                state_next;
  logic [NB_INDEX-1:0]   step_reg;
  logic [NB_INDEX-1:0]   step_next;
  logic [NB_INDEX-1:0]   step_d_reg;
  logic                  valid_d_reg;
  logic                  issue;
  logic [NB_INDEX-1:0]   prev_idx;
  logic [NB_STATE-1:0]   prev_key;
  logic [NB_STATE-1:0]   rd_data;
  logic [NB_STATE-1:0]   rk_reg [0:N_ROUNDS];

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg   <= IDLE;
      step_reg    <= '0;
      step_d_reg  <= '0;
      valid_d_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      step_reg    <= step_next;
      step_d_reg  <= step_reg;
      // A new key drops whatever step is in flight so its result is never
      // written over the fresh expansion.
      valid_d_reg <= i_key_valid ? 1'b0 : issue;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and issue logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
      end
      EXPAND: begin
        issue = (step_reg <= LAST_STEP);
        if (issue) begin
          step_next = step_reg + 1'b1;
        end else begin
          // The last result is captured on this same edge.
          state_next = DONE;
        end
      end
      DONE: begin
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // A key strobe restarts from any state.
    if (i_key_valid) begin
      state_next = EXPAND;
      step_next  = FIRST_STEP;
    end
  end

  // -------------------------------------------------------------------------
  // Round-key register file
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i <= N_ROUNDS; i++) begin
        rk_reg[i] <= '0;
      end
    end else begin
      if (i_key_valid) begin
        rk_reg[0] <= i_key[NB_KEY-1 -: NB_STATE];
        rk_reg[1] <= i_key[NB_STATE-1:0];
      end
      for (int i = 2; i <= N_ROUNDS; i++) begin
        if (valid_d_reg && (step_d_reg == NB_INDEX'(i))) begin
          rk_reg[i] <= i_sched_key_word_n_bus;
        end
      end
    end
  end

  // Step g consumes round key g-2. The mux is written as a compare loop so
  // that out-of-range step values simply select nothing.
  assign prev_idx = step_reg - FIRST_STEP;

  always_comb begin
    prev_key = '0;
    for (int i = 0; i <= N_ROUNDS; i++) begin
      if (issue && (prev_idx == NB_INDEX'(i))) begin
        prev_key = rk_reg[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scheduler-facing outputs (all zero while no step is issued)
  // -------------------------------------------------------------------------
  assign o_sched_valid               = issue;
  assign o_sched_index               = issue ? step_reg : '0;
  assign o_sched_key_word_n_m_nk_bus = prev_key;

  // Word n-1 is the last word of the previous round key. For step 2 that is
  // stored key material; afterwards it is the result the scheduler is
  // presenting this very cycle, fed back without a register so steps issue
  // with no bubbles.
  always_comb begin
    o_sched_key_word_n_m_1 = '0;
    if (issue) begin
      if (step_reg == FIRST_STEP) begin
        o_sched_key_word_n_m_1 = rk_reg[1][NB_WORD-1:0];
      end else begin
        o_sched_key_word_n_m_1 = i_sched_key_word_n_bus[NB_WORD-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered read port; addresses above N_ROUNDS read as zero
  // -------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    for (int i = 0; i <= N_ROUNDS; i++) begin
      if (i_rd_round == NB_INDEX'(i)) begin
        rd_data = rk_reg[i];
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_round_key <= '0;
    end else begin
      o_round_key <= rd_data;
    end
  end

  assign o_busy = (state_reg == EXPAND);
  assign o_done = (state_reg == DONE);

endmodule

// File: tb/tb_key_expansion_controller.sv
// ---------------------------------------------------------------------------
// tb_key_expansion_controller
//
// Drives the controller with the FIPS-197 A.3 key, an all-zero key and
// random keys, including mid-expansion restarts and an asynchronous reset.
// A behavioural AES-256 scheduler closes the loop. Expected scheduler
// issues, o_done rise times and read data are queued by the stimulus and
// consumed by independent monitors.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_key_expansion_controller;

  logic         i_clock = 1'b0;
  logic         i_reset = 1'b1;
  logic [255:0] i_key = '0;
  logic         i_key_valid = 1'b0;
  logic [31:0]  o_sched_key_word_n_m_1;
  logic [127:0] o_sched_key_word_n_m_nk_bus;
  logic [3:0]   o_sched_index;
  logic         o_sched_valid;
  logic [127:0] i_sched_key_word_n_bus;
  logic [3:0]   i_rd_round = '0;
  logic [127:0] o_round_key;
  logic         o_busy;
  logic         o_done;

  key_expansion_controller dut (
    .i_clock                     (i_clock),
    .i_reset                     (i_reset),
    .i_key                       (i_key),
    .i_key_valid                 (i_key_valid),
    .o_sched_key_word_n_m_1      (o_sched_key_word_n_m_1),
    .o_sched_key_word_n_m_nk_bus (o_sched_key_word_n_m_nk_bus),
    .o_sched_index               (o_sched_index),
    .o_sched_valid               (o_sched_valid),
    .i_sched_key_word_n_bus      (i_sched_key_word_n_bus),
    .i_rd_round                  (i_rd_round),
    .o_round_key                 (o_round_key),
    .o_busy                      (o_busy),
    .o_done                      (o_done)
  );

  always #5 i_clock = ~i_clock;

  // -------------------------------------------------------------------------
  // Counters and scoreboard
  // -------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  idx;
    logic [31:0] nm1;
    logic [127:0] nk;
  } issue_t;

  issue_t       issue_q[$];
  int           done_q[$];
  logic [127:0] rd_q[$];
  logic         rd_issue = 1'b0;
  logic         rd_pend = 1'b0;

  logic [7:0]   sbox_t [256];
  logic [127:0] ref_rk [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // AES arithmetic
  // -------------------------------------------------------------------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = '0;
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [31:0] rotw(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] rcon(input int j);
    logic [7:0] r = 8'h01;
    for (int k = 1; k < j; k++) r = xt(r);
    return {r, 24'h0};
  endfunction

  // Reference model: textbook AES-256 expansion over a flat 60-word array.
  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0)      t = subw(rotw(t)) ^ rcon(i / 8);
      else if (i % 8 == 4) t = subw(t);
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Behavioural model of the external scheduler: one 4-word step per issue.
  function automatic logic [127:0] sched_step(input logic [31:0] nm1,
                                              input logic [127:0] prev,
                                              input logic [3:0] g);
    logic [31:0] t, w0, w1, w2, w3;
    if (g[0] == 1'b0) t = subw(rotw(nm1)) ^ rcon(int'(g) / 2);
    else              t = subw(nm1);
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always @(posedge i_clock or posedge i_reset) begin
    if (i_reset) i_sched_key_word_n_bus <= '0;
    else if (o_sched_valid)
      i_sched_key_word_n_bus <= sched_step(o_sched_key_word_n_m_1, o_sched_key_word_n_m_nk_bus, o_sched_index);
  end

  // -------------------------------------------------------------------------
  // Monitors
  // -------------------------------------------------------------------------
  initial forever begin
    @(posedge i_clock);
    cyc++;
  end

  initial forever begin
    @(posedge i_clock or posedge i_reset);
    if (i_reset) rd_pend = 1'b0;
    else         rd_pend = rd_issue;
  end

  initial begin : mon
    issue_t e;
    logic done_prev = 1'b0;
    forever begin
      @(negedge i_clock);
      if (i_reset) begin
        done_prev = 1'b0;
      end else begin
        if (o_sched_valid) begin
          if (issue_q.size() == 0) begin
            chk("sched_valid_unexpected", 128'(o_sched_valid), 128'(0));
          end else begin
            e = issue_q.pop_front();
            chk("issue_cycle", 128'(cyc), 128'(e.cyc));
            chk("sched_index", 128'(o_sched_index), 128'(e.idx));
            chk("word_n_m_1", 128'(o_sched_key_word_n_m_1), 128'(e.nm1));
            chk("word_n_m_nk_bus", o_sched_key_word_n_m_nk_bus, e.nk);
          end
        end else begin
          chk("idle_nk_bus", o_sched_key_word_n_m_nk_bus, 128'(0));
          chk("idle_index_nm1", 128'({o_sched_index, o_sched_key_word_n_m_1}), 128'(0));
        end
        if (o_done && !done_prev) begin
          if (done_q.size() == 0) chk("done_unexpected", 128'(o_done), 128'(0));
          else                    chk("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
        end
        done_prev = o_done;
        if (rd_pend) begin
          if (rd_q.size() == 0) chk("read_unexpected", 128'(rd_pend), 128'(0));
          else                  chk("round_key", o_round_key, rd_q.pop_front());
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (called 1 time unit after a rising edge)
  // -------------------------------------------------------------------------
  task automatic start_key(input logic [255:0] key);
    issue_t e;
    int c0;
    c0 = cyc;
    // A restart keeps only what the old expansion does up to and including
    // the strobe cycle.
    while (issue_q.size() > 0 && issue_q[$].cyc > c0) void'(issue_q.pop_back());
    while (done_q.size() > 0 && done_q[$] > c0) void'(done_q.pop_back());
    expand_key(key);
    for (int g = 2; g <= 14; g++) begin
      e.cyc = c0 + g - 1;
      e.idx = 4'(g);
      e.nm1 = ref_rk[g-1][31:0];
      e.nk  = ref_rk[g-2];
      issue_q.push_back(e);
    end
    done_q.push_back(c0 + 15);
    i_key = key;
    i_key_valid = 1'b1;
    @(posedge i_clock); #1;
    i_key_valid = 1'b0;
    i_key = {8{$urandom}};
    chk("busy_after_start", 128'(o_busy), 128'(1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!o_done && n < 40) begin
      @(posedge i_clock); #1;
      n++;
    end
    chk("done_seen", 128'(o_done), 128'(1));
    chk("busy_in_done", 128'(o_busy), 128'(0));
  endtask

  task automatic do_read(input logic [3:0] a, input logic [127:0] exp);
    i_rd_round = a;
    rd_issue = 1'b1;
    rd_q.push_back(exp);
    @(posedge i_clock); #1;
    rd_issue = 1'b0;
  endtask

  task automatic sweep();
    for (int a = 0; a < 16; a++) begin
      if (a <= 14) do_read(4'(a), ref_rk[a]);
      else         do_read(4'(a), 128'(0));
    end
    for (int k = 0; k < 4; k++) begin
      int a = $urandom_range(0, 14);
      do_read(4'(a), ref_rk[a]);
    end
    repeat (2) begin @(posedge i_clock); #1; end
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [255:0] k1, k2;
    int kr;
    build_sbox();
    repeat (2) @(posedge i_clock);
    #1;
    chk("rst_done", 128'(o_done), 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_sched_valid", 128'(o_sched_valid), 128'(0));
    chk("rst_round_key", o_round_key, 128'(0));
    i_reset = 1'b0;
    @(posedge i_clock); #1;
    do_read(4'd0, 128'(0));
    repeat (2) begin @(posedge i_clock); #1; end

    // FIPS-197 A.3
    start_key(KEY_A3);
    wait_done();
    do_read(4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde);
    do_read(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
    do_read(4'd0,  KEY_A3[255:128]);
    do_read(4'd1,  KEY_A3[127:0]);
    sweep();

    // Random keys
    for (int t = 0; t < 4; t++) begin
      start_key({8{$urandom}});
      wait_done();
      sweep();
    end

    // Restart at cycle 7 with the all-zero key
    start_key(KEY_A3);
    repeat (6) begin @(posedge i_clock); #1; end
    start_key(256'h0);
    wait_done();
    sweep();

    // Restarts at random points, including the cycle the old o_done rises
    for (int t = 0; t < 4; t++) begin
      k1 = {8{$urandom}};
      k2 = {8{$urandom}};
      kr = (t == 0) ? 15 : $urandom_range(1, 14);
      start_key(k1);
      repeat (kr - 1) begin @(posedge i_clock); #1; end
      start_key(k2);
      wait_done();
      sweep();
    end

    // Asynchronous reset in the middle of an expansion
    i_rd_round = 4'd14;
    start_key({8{$urandom}});
    repeat (4) begin @(posedge i_clock); #1; end
    #1;
    i_reset = 1'b1;
    #1;
    chk("arst_done", 128'(o_done), 128'(0));
    chk("arst_busy", 128'(o_busy), 128'(0));
    chk("arst_sched_valid", 128'(o_sched_valid), 128'(0));
    chk("arst_sched_index", 128'(o_sched_index), 128'(0));
    chk("arst_word_n_m_1", 128'(o_sched_key_word_n_m_1), 128'(0));
    chk("arst_nk_bus", o_sched_key_word_n_m_nk_bus, 128'(0));
    chk("arst_round_key", o_round_key, 128'(0));
    issue_q.delete();
    done_q.delete();
    rd_q.delete();
    rd_issue = 1'b0;
    @(posedge i_clock); #2;
    i_reset = 1'b0;
    @(posedge i_clock); #1;
    chk("post_rst_done", 128'(o_done), 128'(0));
    chk("post_rst_busy", 128'(o_busy), 128'(0));
    do_read(4'd0, 128'(0));
    repeat (4) begin @(posedge i_clock); #1; end

    chk("issue_q_left", 128'(issue_q.size()), 128'(0));
    chk("done_q_left", 128'(done_q.size()), 128'(0));
    chk("rd_q_left", 128'(rd_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
